sync_fifo_param: RTL

Parametrised single-clock FIFO implemented in plain RTL, with no vendor IP.
- Generalises the existing 8-bit fixed FIFO in data width, depth and read mode (standard or first-word-fall-through).
- Adds programmable almost-full/almost-empty flags, an occupancy count, and overflow/underflow error pulses.
- Used as the generic buffering primitive between streaming blocks in the same clock domain.

---
 rtl/sync_fifo_pkg.sv | 14 +
 rtl/sync_fifo_mem.sv | 44 ++++
 rtl/sync_fifo_param.sv | 110 +++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
// Read-mode selector plus a constant power-of-two test used by the parameter checks.
package sync_fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage: synchronous write, registered or asynchronous read.
// Registered read: 1-cycle latency, output holds when re is low; no backpressure of its own.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = $clog2(DEPTH),
  parameter bit REG_OUT    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Storage is deliberately left out of reset so it can map onto plain RAM.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata <= '0;
        end else if (re) begin
          rdata <= mem[raddr];
        end
      end
    end else begin : g_async
      assign rdata = mem[raddr];
      logic unused_ctl;
      assign unused_ctl = re ^ rst;
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read mode.
// STD: dout valid 1 cycle after an accepted rd_en; FWFT: head visible while !empty. Writes when full / reads when empty are dropped and flagged.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter int         DEPTH      = 16,
  parameter fifo_mode_e MODE       = FIFO_STD,
  parameter int         AF_LEVEL   = DEPTH - 2,
  parameter int         AE_LEVEL   = 2,
  localparam int        CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         data_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int            AW      = CW - 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_param: DATA_WIDTH must be >= 1");
  end
  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and >= 4");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_param: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          wr_acc;
  logic          rd_acc;

  // Flags decode the registered count only, so they never glitch on input changes.
  assign full         = (data_count == DEPTH_C);
  assign empty        = (data_count == '0);
  assign almost_full  = (data_count >= AF_C);
  assign almost_empty = (data_count <= AE_C);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    count_nxt = data_count;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = data_count + CW'(1);
      2'b01:   count_nxt = data_count - CW'(1);
      default: count_nxt = data_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + CW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + CW'(1);
      end
      data_count <= count_nxt;
      overflow   <= wr_en && full;
      underflow  <= rd_en && empty;
    end
  end

  // The wrap bits only matter for pointer bookkeeping; occupancy comes from data_count.
  logic unused_wrap;
  assign unused_wrap = wr_ptr[CW-1] ^ rd_ptr[CW-1];

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW),
    .REG_OUT    (MODE == FIFO_STD)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (dout)
  );

endmodule
